// File: rtl/uart_tx_engine.sv
// uart_tx_engine: captures a byte plus framing configuration on a load strobe,
// serialises an 11-bit frame (start, 7/8 data bits, optional parity, stop)
// on tx, LSB first, and pulses tx_done for one cycle at the end of the frame.
// Optional feature macro: UART_TX_PARITY_EN (parity generation). When the
// macro is undefined, pen/ohel are ignored and frames are built as if pen=0.
module uart_tx_engine #(
    parameter int CLK_HZ = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] din,
    input  logic       eight,
    input  logic       pen,
    input  logic       ohel,
    input  logic [3:0] baud_sel,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Nearest-integer clock divisor for a given baud rate.
    function automatic logic [19:0] round_div(input int rate);
        longint q;
        q = (longint'(CLK_HZ) + longint'(rate / 2)) / longint'(rate);
        return q[19:0];
    endfunction

    localparam logic [19:0] K_300    = round_div(300);
    localparam logic [19:0] K_1200   = round_div(1200);
    localparam logic [19:0] K_2400   = round_div(2400);
    localparam logic [19:0] K_4800   = round_div(4800);
    localparam logic [19:0] K_9600   = round_div(9600);
    localparam logic [19:0] K_19200  = round_div(19200);
    localparam logic [19:0] K_38400  = round_div(38400);
    localparam logic [19:0] K_57600  = round_div(57600);
    localparam logic [19:0] K_115200 = round_div(115200);
    localparam logic [19:0] K_230400 = round_div(230400);
    localparam logic [19:0] K_460800 = round_div(460800);
    localparam logic [19:0] K_921600 = round_div(921600);

    // Rate index to divisor; indexes above 11 saturate to the fastest rate.
    function automatic logic [19:0] baud_div(input logic [3:0] sel);
        case (sel)
            4'd0:    return K_300;
            4'd1:    return K_1200;
            4'd2:    return K_2400;
            4'd3:    return K_4800;
            4'd4:    return K_9600;
            4'd5:    return K_19200;
            4'd6:    return K_38400;
            4'd7:    return K_57600;
            4'd8:    return K_115200;
            4'd9:    return K_230400;
            4'd10:   return K_460800;
            default: return K_921600;
        endcase
    endfunction

    state_t      state, state_nx;
    logic [19:0] div_q, div_nx;
    logic [19:0] cnt_q, cnt_nx;
    logic [3:0]  bit_q, bit_nx;
    logic [9:0]  frame_q, frame_nx;   // frame bits 1..10; the start bit goes straight to tx
    logic        tx_q, tx_nx;
    logic        done_q, done_nx;

    logic        pen_eff;
    logic        par_bit;
    logic [9:0]  frame_body;

`ifdef UART_TX_PARITY_EN
    // Parity over the active data bits; odd parity inverts the even result.
    always_comb begin
        pen_eff = pen;
        par_bit = (^(eight ? din : {1'b0, din[6:0]})) ^ ohel;
    end
`else
    logic unused_cfg;
    assign unused_cfg = &{pen, ohel};

    // Parity disabled: every frame is built as if pen=0.
    always_comb begin
        pen_eff = 1'b0;
        par_bit = 1'b1;
    end
`endif

    // Assemble frame bits 1..10 from the inputs presented with load.
    always_comb begin
        if (eight)
            frame_body = {1'b1, (pen_eff ? par_bit : 1'b1), din};
        else
            frame_body = {2'b11, (pen_eff ? par_bit : 1'b1), din[6:0]};
    end

    // Next-state logic: accept a load in IDLE, time each bit for k clocks in SHIFT.
    always_comb begin
        state_nx = state;
        div_nx   = div_q;
        cnt_nx   = cnt_q;
        bit_nx   = bit_q;
        frame_nx = frame_q;
        tx_nx    = tx_q;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                tx_nx = 1'b1;
                if (load) begin
                    state_nx = SHIFT;
                    frame_nx = frame_body;
                    tx_nx    = 1'b0;
                    div_nx   = baud_div(baud_sel);
                    cnt_nx   = 20'd0;
                    bit_nx   = 4'd0;
                end
            end
            SHIFT: begin
                if (cnt_q == div_q - 20'd1) begin
                    cnt_nx = 20'd0;
                    if (bit_q == 4'd10) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                        tx_nx    = 1'b1;
                        frame_nx = '1;
                        bit_nx   = 4'd0;
                    end else begin
                        bit_nx   = bit_q + 4'd1;
                        tx_nx    = frame_q[0];
                        frame_nx = {1'b1, frame_q[9:1]};
                    end
                end else begin
                    cnt_nx = cnt_q + 20'd1;
                end
            end
        endcase
    end

    // State and datapath registers; reset forces the line idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            div_q   <= 20'd0;
            cnt_q   <= 20'd0;
            bit_q   <= 4'd0;
            frame_q <= '1;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            div_q   <= div_nx;
            cnt_q   <= cnt_nx;
            bit_q   <= bit_nx;
            frame_q <= frame_nx;
            tx_q    <= tx_nx;
            done_q  <= done_nx;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state == SHIFT);
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Testbench for uart_tx_engine at CLK_HZ = 10 MHz, where the divisors are
// idx8:87, idx9:43, idx10:22, idx11..15:11, idx4:1042.
module tb_uart_tx_engine;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] din;
    logic       eight, pen, ohel;
    logic [3:0] baud_sel;
    logic       tx, tx_busy, tx_done;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_engine #(.CLK_HZ(10000000)) dut (
        .clk(clk), .rst(rst), .load(load), .din(din), .eight(eight),
        .pen(pen), .ohel(ohel), .baud_sel(baud_sel),
        .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        logic [7:0]  din;
        logic        eight;
        logic        pen;
        logic        ohel;
        logic [3:0]  sel;
        logic [10:0] frame;
        int          k;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present a load for one cycle (called just after a falling edge), then
    // scramble every config input so the frame in flight must not follow them.
    task automatic start_load(input logic [7:0] d, input logic e, input logic p,
                              input logic o, input logic [3:0] s);
        din = d; eight = e; pen = p; ohel = o; baud_sel = s;
        load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        din = ~din; eight = ~eight; pen = ~pen; ohel = ~ohel;
        baud_sel = baud_sel ^ 4'hF;
    endtask

    // Entered at the falling edge of cycle N+1; returns at the falling edge of
    // the tx_done cycle N+1+11k. Optionally injects a load at relative cycle inj_c.
    task automatic check_frame(input string nm, input logic [10:0] exp, input int k,
                               input int inj_c);
        int bad_tx = 0;
        int bad_busy = 0;
        int bad_done = 0;
        int bi;
        for (int c = 1; c <= 11 * k + 1; c++) begin
            if (c <= 11 * k) begin
                bi = (c - 1) / k;
                if (tx !== exp[bi]) bad_tx++;
                if (tx_busy !== 1'b1) bad_busy++;
                if (tx_done !== 1'b0) bad_done++;
                if ((c - 1 - bi * k) == k / 2)
                    chk($sformatf("%s bit%0d", nm, bi), tx, exp[bi]);
            end else begin
                chk($sformatf("%s done_pulse", nm), tx_done, 1);
                chk($sformatf("%s busy_at_done", nm), tx_busy, 0);
                chk($sformatf("%s tx_at_done", nm), tx, 1);
            end
            if (c == inj_c) begin
                load = 1'b1;
                din  = 8'h00;
            end else if (c == inj_c + 1) begin
                load = 1'b0;
            end
            if (c < 11 * k + 1) @(negedge clk);
        end
        chk($sformatf("%s tx_every_cycle_errs", nm), bad_tx, 0);
        chk($sformatf("%s busy_window_errs", nm), bad_busy, 0);
        chk($sformatf("%s early_done_errs", nm), bad_done, 0);
    endtask

    // Watch an idle line for n cycles: tx high, not busy, no done pulse.
    task automatic check_quiet(input string nm, input int n);
        int bad = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        chk(nm, bad, 0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 4'd11, {2'b11, 8'hA5, 1'b0}, 11};
        vecs[1] = '{8'h41, 1'b0, 1'b1, 1'b1, 4'd11, {3'b111, 7'h41, 1'b0}, 11};
        vecs[2] = '{8'h41, 1'b0, 1'b0, 1'b0, 4'd10, {3'b111, 7'h41, 1'b0}, 22};
        vecs[3] = '{8'h41, 1'b0, 1'b1, 1'b0, 4'd12, {2'b11, (PAR_ON ? 1'b0 : 1'b1), 7'h41, 1'b0}, 11};
        vecs[4] = '{8'hC3, 1'b1, 1'b1, 1'b0, 4'd9,  {1'b1, (PAR_ON ? 1'b0 : 1'b1), 8'hC3, 1'b0}, 43};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b1, 4'd15, {1'b1, (PAR_ON ? 1'b0 : 1'b1), 8'h80, 1'b0}, 11};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 1'b1, 4'd8,  {2'b11, (PAR_ON ? 1'b0 : 1'b1), 7'h7F, 1'b0}, 87};
        vecs[7] = '{8'h3C, 1'b1, 1'b1, 1'b1, 4'd13, {1'b1, 1'b1, 8'h3C, 1'b0}, 11};

        load = 1'b0; din = 8'h00; eight = 1'b1; pen = 1'b0; ohel = 1'b0; baud_sel = 4'd11;

        // Reset with the clock stopped.
        rst = 1'b1;
        #3;
        chk("reset tx", tx, 1);
        chk("reset busy", tx_busy, 0);
        chk("reset done", tx_done, 0);
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_quiet("idle after reset", 5);

        // Table-driven frames.
        for (int i = 0; i < 8; i++) begin
            start_load(vecs[i].din, vecs[i].eight, vecs[i].pen, vecs[i].ohel, vecs[i].sel);
            check_frame($sformatf("vec%0d", i), vecs[i].frame, vecs[i].k, -1);
            repeat (2) @(negedge clk);
        end

        // Load while busy is ignored; nothing queued afterwards.
        start_load(8'hA5, 1'b1, 1'b0, 1'b0, 4'd11);
        check_frame("busy_ignore", {2'b11, 8'hA5, 1'b0}, 11, 5 * 11 + 6);
        check_quiet("no queued frame", 60);

        // Load in the tx_done cycle starts the next frame with no gap.
        start_load(8'hA5, 1'b1, 1'b0, 1'b0, 4'd11);
        check_frame("b2b_first", {2'b11, 8'hA5, 1'b0}, 11, -1);
        start_load(8'h00, 1'b1, 1'b0, 1'b0, 4'd11);
        check_frame("b2b_second", {2'b11, 8'h00, 1'b0}, 11, -1);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of bit 4.
        start_load(8'hA5, 1'b1, 1'b0, 1'b0, 4'd11);
        repeat (4 * 11 + 5) @(negedge clk);
        chk("pre-reset bit4", tx, 0);
        #1;
        rst = 1'b1;
        #1;
        chk("midframe reset tx", tx, 1);
        chk("midframe reset busy", tx_busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_quiet("no done after reset", 30);
        start_load(8'hC3, 1'b1, 1'b0, 1'b0, 4'd11);
        check_frame("after_reset", {2'b11, 8'hC3, 1'b0}, 11, -1);
        repeat (2) @(negedge clk);

        // baud_sel changes 11 -> 4 during a frame; next frame uses the new rate.
        start_load(8'hA5, 1'b1, 1'b0, 1'b0, 4'd11);
        chk("baud_sel moved", baud_sel, 4);
        check_frame("sal_first", {2'b11, 8'hA5, 1'b0}, 11, -1);
        repeat (2) @(negedge clk);
        start_load(8'h5A, 1'b1, 1'b0, 1'b0, 4'd4);
        check_frame("sal_slow", {2'b11, 8'h5A, 1'b0}, 1042, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
